timer_irq_ctrl: RTL

Downstream event collector for the 8-bit timer/counter. It consumes the timer's `TMR_OVF` / `TMR_UDF` flags and turns each rising edge into a sticky interrupt-status bit and a saturating event count. It drives a single maskable interrupt line and exposes its registers on its own APB slave port, which shares `pclk` with the timer.

---
 rtl/timer_irq_ctrl_if.sv | 24 ++
 rtl/timer_irq_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl_if.sv
// APB slave bus bundle for timer_irq_ctrl.
interface timer_irq_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Timer overflow/underflow event collector: sticky ISR, saturating counters, maskable irq.
// Optional input synchronizers are enabled by defining TIMER_IRQ_SYNC_EN.
module timer_irq_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic             pclk,
  input  logic             preset,
  timer_irq_ctrl_if.slave  apb,
  input  logic             tmr_ovf,
  input  logic             tmr_udf,
  output logic             irq
);
  localparam logic [2:0]            A_IER  = 3'd0;
  localparam logic [2:0]            A_ISR  = 3'd1;
  localparam logic [2:0]            A_OCNT = 3'd2;
  localparam logic [2:0]            A_UCNT = 3'd3;
  localparam logic [2:0]            A_CTRL = 3'd4;
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            r_ier;
  logic [1:0]            r_isr;
  logic [DATA_WIDTH-1:0] r_cnt_ovf;
  logic [DATA_WIDTH-1:0] r_cnt_udf;
  logic                  r_force;
  logic                  r_ovf_q;
  logic                  r_udf_q;
  logic                  r_irq;

  logic                  w_ovf_in;
  logic                  w_udf_in;
  logic                  w_ev_ovf;
  logic                  w_ev_udf;
  logic [2:0]            w_idx;
  logic                  w_access;
  logic                  w_unmapped;
  logic                  w_wr;
  logic                  w_cnt_clr;
  logic [1:0]            w_isr_next;
  logic [DATA_WIDTH-1:0] w_cnt_ovf_next;
  logic [DATA_WIDTH-1:0] w_cnt_udf_next;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

`ifdef TIMER_IRQ_SYNC_EN
  logic [1:0] r_ovf_sync;
  logic [1:0] r_udf_sync;

  // Two-flop synchronizers ahead of edge detection
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ovf_sync <= '0;
      r_udf_sync <= '0;
    end else begin
      r_ovf_sync <= {r_ovf_sync[0], tmr_ovf};
      r_udf_sync <= {r_udf_sync[0], tmr_udf};
    end
  end

  assign w_ovf_in = r_ovf_sync[1];
  assign w_udf_in = r_udf_sync[1];
`else
  assign w_ovf_in = tmr_ovf;
  assign w_udf_in = tmr_udf;
`endif

  assign w_ev_ovf   = w_ovf_in & ~r_ovf_q;
  assign w_ev_udf   = w_udf_in & ~r_udf_q;

  assign w_idx      = apb.paddr[2:0];
  assign w_access   = apb.psel & apb.penable;
  assign w_unmapped = (w_idx > A_CTRL);
  assign w_wr       = w_access & apb.pwrite & ~w_unmapped;
  assign w_cnt_clr  = w_wr & (w_idx == A_CTRL) & apb.pwdata[0];
  assign w_unused   = &{1'b0, apb.pwdata[DATA_WIDTH-1:2]};

  // Event set beats W1C; counter clear still keeps a same-edge event
  always_comb begin
    w_isr_next = r_isr;
    if (w_wr && (w_idx == A_ISR)) w_isr_next = w_isr_next & ~apb.pwdata[1:0];
    w_isr_next = w_isr_next | {w_ev_udf, w_ev_ovf};

    w_cnt_ovf_next = w_cnt_clr ? '0 : r_cnt_ovf;
    w_cnt_udf_next = w_cnt_clr ? '0 : r_cnt_udf;
    if (w_ev_ovf && (w_cnt_ovf_next != CNT_MAX))
      w_cnt_ovf_next = w_cnt_ovf_next + DATA_WIDTH'(1);
    if (w_ev_udf && (w_cnt_udf_next != CNT_MAX))
      w_cnt_udf_next = w_cnt_udf_next + DATA_WIDTH'(1);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ier     <= '0;
      r_isr     <= '0;
      r_cnt_ovf <= '0;
      r_cnt_udf <= '0;
      r_force   <= 1'b0;
      r_ovf_q   <= 1'b0;
      r_udf_q   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ovf_q   <= w_ovf_in;
      r_udf_q   <= w_udf_in;
      r_isr     <= w_isr_next;
      r_cnt_ovf <= w_cnt_ovf_next;
      r_cnt_udf <= w_cnt_udf_next;
      if (w_wr && (w_idx == A_IER))  r_ier   <= apb.pwdata[1:0];
      if (w_wr && (w_idx == A_CTRL)) r_force <= apb.pwdata[1];
      r_irq     <= (|(r_isr & r_ier)) | r_force;
    end
  end

  // Combinational read path, zero outside a read access
  always_comb begin
    w_rdata = '0;
    if (w_access && !apb.pwrite) begin
      case (w_idx)
        A_IER:   w_rdata = {{(DATA_WIDTH-2){1'b0}}, r_ier};
        A_ISR:   w_rdata = {{(DATA_WIDTH-2){1'b0}}, r_isr};
        A_OCNT:  w_rdata = r_cnt_ovf;
        A_UCNT:  w_rdata = r_cnt_udf;
        A_CTRL:  w_rdata = {{(DATA_WIDTH-2){1'b0}}, r_force, 1'b0};
        default: w_rdata = '0;
      endcase
    end
  end

  assign apb.prdata  = w_rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = w_access & w_unmapped;
  assign irq         = r_irq;
endmodule
